// File: rtl/bif_pkg.sv
// Shared types for the BIF BD<->LBD sequencer: FSM states, strobe bundle
// and the per-state strobe decode used to load the output register.
package bif_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_DATA, S_WAIT, S_LATCH, S_DONE
  } state_t;

  // Inactive levels of the active-low strobes.
  localparam logic BREQ_OFF     = 1'b1;
  localparam logic BGNTCACT_OFF = 1'b1;
  localparam logic EBD_OFF      = 1'b1;
  localparam logic WBD_OFF      = 1'b1;

  typedef struct packed {
    logic breq_n;
    logic bgntcact_n;
    logic ebadr;
    logic ebd_n;
    logic wbd_n;
    logic clkbd;
    logic busy;
    logic done;
    logic tmo;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{breq_n: BREQ_OFF, bgntcact_n: BGNTCACT_OFF,
                                ebadr: 1'b0, ebd_n: EBD_OFF, wbd_n: WBD_OFF,
                                clkbd: 1'b0, busy: 1'b0, done: 1'b0, tmo: 1'b0};

  function automatic ctl_t ctl_decode(input state_t s, input logic wr_q,
                                      input logic tmo_hit);
    ctl_t c;
    c = CTL_IDLE;
    case (s)
      S_ARB: begin
        c.breq_n = 1'b0;
        c.busy   = 1'b1;
      end
      S_ADDR: begin
        c.breq_n     = 1'b0;
        c.bgntcact_n = 1'b0;
        c.ebadr      = 1'b1;
        c.ebd_n      = 1'b0;
        c.wbd_n      = 1'b0;
        c.busy       = 1'b1;
      end
      // Reads release the BD drivers here for bus turnaround.
      S_DATA, S_WAIT: begin
        c.breq_n     = 1'b0;
        c.bgntcact_n = 1'b0;
        c.ebd_n      = wr_q ? 1'b0 : EBD_OFF;
        c.wbd_n      = wr_q ? 1'b0 : WBD_OFF;
        c.busy       = 1'b1;
      end
      S_LATCH: begin
        c.breq_n     = 1'b0;
        c.bgntcact_n = 1'b0;
        c.clkbd      = 1'b1;
        c.busy       = 1'b1;
      end
      S_DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
        c.tmo  = tmo_hit;
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bif_tmo_cnt.sv
// Saturating wait counter; o_tc flags the TMO_CYC-th counted cycle.
module bif_tmo_cnt #(
  parameter int TMO_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_cnt <= '0;
    else if (i_clr)                            r_cnt <= '0;
    else if (i_en && r_cnt != CW'(TMO_CYC))    r_cnt <= r_cnt + 1'b1;
  end

  // Terminal while sitting in the last allowed cycle of the wait.
  assign o_tc = (r_cnt >= CW'(TMO_CYC - 1));

endmodule

// File: rtl/bif_bdlbd_seq.sv
// BIF BD<->LBD transfer sequencer: arbitration, address/data phases, ack wait
// and read capture, with all datapath strobes driven from a register.
module bif_bdlbd_seq
  import bif_pkg::*;
#(
  parameter int ADDR_CYC = 2,
  parameter int TMO_CYC  = 255
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  input  logic req,
  input  logic wr,
  input  logic BGNT_n,
  input  logic BACK_n,
  output logic BREQ_n,
  output logic BGNTCACT_n,
  output logic EBADR,
  output logic EBD_n,
  output logic WBD_n,
  output logic CLKBD,
  output logic busy,
  output logic done,
  output logic tmo
);

  localparam int AW = (ADDR_CYC > 1) ? $clog2(ADDR_CYC) : 1;

  state_t        r_state;
  state_t        w_nxt;
  logic          r_wr_q;
  logic          w_wr_nxt;
  logic [AW-1:0] r_acnt;
  logic          w_acnt_last;
  logic          w_tmo_hit;
  logic          w_tc;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  ctl_t          r_ctl;

  bif_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .i_clk   (sysclk),
    .i_rst_n (sys_rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  // Counter is held clear outside the two waiting states so each wait starts at 0.
  assign w_cnt_en    = (r_state == S_ARB) || (r_state == S_WAIT);
  assign w_cnt_clr   = !w_cnt_en || ((r_state == S_ARB) && !BGNT_n);
  assign w_acnt_last = (r_acnt == AW'(ADDR_CYC - 1));

  always_comb begin
    w_nxt     = r_state;
    w_tmo_hit = 1'b0;
    w_wr_nxt  = r_wr_q;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_nxt    = S_ARB;
          w_wr_nxt = wr;
        end
      end
      // Grant/ack is checked before the terminal count so it wins a tie.
      S_ARB: begin
        if (!BGNT_n) w_nxt = S_ADDR;
        else if (w_tc) begin
          w_nxt     = S_DONE;
          w_tmo_hit = 1'b1;
        end
      end
      S_ADDR:  if (w_acnt_last) w_nxt = S_DATA;
      S_DATA:  w_nxt = S_WAIT;
      S_WAIT: begin
        if (!BACK_n) w_nxt = r_wr_q ? S_DONE : S_LATCH;
        else if (w_tc) begin
          w_nxt     = S_DONE;
          w_tmo_hit = 1'b1;
        end
      end
      S_LATCH: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_wr_q  <= 1'b0;
      r_acnt  <= '0;
      r_ctl   <= CTL_IDLE;
    end else begin
      r_state <= w_nxt;
      r_wr_q  <= w_wr_nxt;
      r_acnt  <= ((r_state == S_ADDR) && !w_acnt_last) ? r_acnt + 1'b1 : '0;
      r_ctl   <= ctl_decode(w_nxt, w_wr_nxt, w_tmo_hit);
    end
  end

  assign BREQ_n     = r_ctl.breq_n;
  assign BGNTCACT_n = r_ctl.bgntcact_n;
  assign EBADR      = r_ctl.ebadr;
  assign EBD_n      = r_ctl.ebd_n;
  assign WBD_n      = r_ctl.wbd_n;
  assign CLKBD      = r_ctl.clkbd;
  assign busy       = r_ctl.busy;
  assign done       = r_ctl.done;
  assign tmo        = r_ctl.tmo;

endmodule

// File: tb/tb_bif_bdlbd_seq.sv
// Bench for bif_bdlbd_seq: per-transfer expected strobe traces built from
// phase lengths, compared every cycle against the DUT outputs.
module tb_bif_bdlbd_seq;

  localparam int ADDR_CYC = 2;
  localparam int TMO      = 6;

  // {BREQ_n,BGNTCACT_n,EBADR,EBD_n,WBD_n,CLKBD,busy,done,tmo}
  localparam logic [8:0] V_IDLE = 9'b110110000;
  localparam logic [8:0] V_ARB  = 9'b010110100;
  localparam logic [8:0] V_ADDR = 9'b001000100;
  localparam logic [8:0] V_DW   = 9'b000000100;
  localparam logic [8:0] V_DR   = 9'b000110100;
  localparam logic [8:0] V_LAT  = 9'b000111100;
  localparam logic [8:0] V_DONE = 9'b110110110;
  localparam logic [8:0] V_DTMO = 9'b110110111;

  logic sysclk = 1'b0;
  logic sys_rst_n, req, wr, BGNT_n, BACK_n;
  logic BREQ_n, BGNTCACT_n, EBADR, EBD_n, WBD_n, CLKBD, busy, done, tmo;
  logic [8:0] obs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sysclk = ~sysclk;

  bif_bdlbd_seq #(.ADDR_CYC(ADDR_CYC), .TMO_CYC(TMO)) dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .req(req), .wr(wr),
    .BGNT_n(BGNT_n), .BACK_n(BACK_n), .BREQ_n(BREQ_n), .BGNTCACT_n(BGNTCACT_n),
    .EBADR(EBADR), .EBD_n(EBD_n), .WBD_n(WBD_n), .CLKBD(CLKBD),
    .busy(busy), .done(done), .tmo(tmo)
  );

  assign obs = {BREQ_n, BGNTCACT_n, EBADR, EBD_n, WBD_n, CLKBD, busy, done, tmo};

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // One transfer: g = ARB cycle in which the grant shows, a = WAIT cycle in
  // which ack shows; values >= TMO mean it never arrives in time.
  task automatic run_txn(input string tag, input bit w, input int g, input int a,
                         input bit hold);
    logic [8:0] ex[$];
    bit gl[$];
    bit al[$];
    int n_arb, n_wait;
    ex.push_back(V_IDLE); gl.push_back(0); al.push_back(0);
    n_arb = (g >= TMO) ? TMO : g + 1;
    for (int i = 0; i < n_arb; i++) begin
      ex.push_back(V_ARB); gl.push_back(i == g); al.push_back(0);
    end
    if (g >= TMO) begin
      ex.push_back(V_DTMO); gl.push_back(0); al.push_back(0);
    end else begin
      for (int i = 0; i < ADDR_CYC; i++) begin
        ex.push_back(V_ADDR); gl.push_back(0); al.push_back(0);
      end
      ex.push_back(w ? V_DW : V_DR); gl.push_back(0); al.push_back(0);
      n_wait = (a >= TMO) ? TMO : a + 1;
      for (int i = 0; i < n_wait; i++) begin
        ex.push_back(w ? V_DW : V_DR); gl.push_back(0); al.push_back(i == a);
      end
      if (a >= TMO) begin
        ex.push_back(V_DTMO); gl.push_back(0); al.push_back(0);
      end else begin
        if (!w) begin
          ex.push_back(V_LAT); gl.push_back(0); al.push_back(0);
        end
        ex.push_back(V_DONE); gl.push_back(0); al.push_back(0);
      end
    end
    for (int i = 0; i < ex.size(); i++) begin
      req    = hold ? 1'b1 : (i == 0);
      wr     = (i == 0) ? w : 1'($urandom);
      BGNT_n = !gl[i];
      BACK_n = !al[i];
      check($sformatf("%s[c%0d]", tag, i), obs, ex[i]);
      step();
    end
  endtask

  initial begin
    sys_rst_n = 1'b0; req = 1'b0; wr = 1'b0; BGNT_n = 1'b1; BACK_n = 1'b1;
    step();
    check("reset", obs, V_IDLE);
    sys_rst_n = 1'b1;
    step();
    check("idle_after_reset", obs, V_IDLE);

    run_txn("wr_imm",      1'b1, 0, 0, 1'b0);
    run_txn("rd_ack5",     1'b0, 0, 5, 1'b0);
    run_txn("rd_g2a1",     1'b0, 2, 1, 1'b0);
    run_txn("arb_tmo",     1'b1, TMO, 0, 1'b0);
    run_txn("gnt_tc",      1'b0, TMO - 1, 0, 1'b0);
    run_txn("ack_tc",      1'b1, 0, TMO - 1, 1'b0);
    run_txn("wait_tmo_rd", 1'b0, 1, TMO, 1'b0);
    run_txn("wait_tmo_wr", 1'b1, 0, TMO, 1'b0);

    // Back-to-back with req held high; wr is random every cycle.
    for (int k = 0; k < 6; k++)
      run_txn($sformatf("hold%0d", k), 1'($urandom), $urandom_range(0, 2),
              $urandom_range(0, 3), 1'b1);
    req = 1'b0;
    step();
    check("idle_after_hold", obs, V_IDLE);

    for (int k = 0; k < 20; k++)
      run_txn($sformatf("rnd%0d", k), 1'($urandom), $urandom_range(0, TMO + 1),
              $urandom_range(0, TMO + 1), 1'($urandom));
    req = 1'b0;
    step();

    // Asynchronous reset while in ADDR.
    req = 1'b1; wr = 1'b1; BGNT_n = 1'b1; BACK_n = 1'b1;
    step();
    req = 1'b0; BGNT_n = 1'b0;
    check("rst_arb", obs, V_ARB);
    step();
    BGNT_n = 1'b1;
    check("rst_addr", obs, V_ADDR);
    #2 sys_rst_n = 1'b0;
    #1 check("rst_async", obs, V_IDLE);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_hold%0d", i), obs, V_IDLE);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_nodone%0d", i), obs, V_IDLE);
    end
    run_txn("post_rst_rd", 1'b0, 1, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
